// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared types for the single-cycle valid/ready memory protocol endpoints.
//   mem_req_t    : one captured request (valid, instr tag, byte addr, wdata, wstrb)
//   mem_state_e  : responder state machine encoding (IDLE, WAIT, RESP)
//   idx_in_range : range check of a full 30-bit word index against an array depth
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } mem_state_e;

    localparam logic [3:0] STRB_READ = 4'h0;

    // Compare the whole word index so that high address bits can never alias
    // back into the array.
    function automatic logic idx_in_range(input logic [29:0] idx, input int words);
        return {2'b00, idx} < $unsigned(words);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Single-cycle valid/ready memory bus.
//   master : drives memory_valid/instr/addr/wdata/wstrb, receives rdata/ready/error
//   slave  : the opposite direction (used by mem_responder)
// -----------------------------------------------------------------------------
interface mem_responder_if;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic        memory_error;

    modport master (
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready, memory_error
    );

    modport slave (
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready, memory_error
    );
endinterface

// File: rtl/mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port WORDS x 32 storage with byte-lane write strobes and a registered
// read port.
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_en           : access strobe for this edge
//   i_idx          : word index
//   i_wstrb        : byte enables; 0 selects a read
//   i_wdata        : write data
//   o_rdata        : read data; non-zero only in the cycle after a read access
// -----------------------------------------------------------------------------
module mem_array #(
    parameter  int WORDS = 1024,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_wstrb,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    import mem_responder_pkg::*;

    // Storage is deliberately not reset so contents survive a responder reset.
    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // The read register returns to zero whenever no read was performed, so the
    // bus rdata is zero outside the completion cycle without extra masking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en && i_wstrb == STRB_READ) begin
            r_rdata <= r_mem[i_idx];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Slow-side responder: accepts one-cycle request pulses, holds each for
// WAIT_STATES cycles, then performs a byte-strobed access on an internal array
// and returns a one-cycle ready pulse. A one-entry pending slot absorbs a
// back-to-back request; anything beyond that is dropped and flagged.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : mem_responder_if.slave (request in, rdata/ready/error out)
//   o_overflow     : sticky dropped-request flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORDS       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mem_responder_if.slave  bus,
    output logic            o_overflow
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

    mem_state_e  r_state;
    mem_req_t    r_act;
    mem_req_t    r_pend;
    logic [CW-1:0] r_cnt;
    logic        r_ready;
    logic        r_error;
    logic        r_overflow;

    mem_req_t    w_in;
    mem_req_t    w_load_req;
    mem_req_t    w_acc;
    logic        w_load_new;
    logic        w_promote;
    logic        w_load;
    logic        w_go_resp;
    logic        w_acc_ok;
    logic        w_arr_en;
    logic        w_pend_fill;
    logic        w_drop;
    logic [31:0] w_rdata;

    always_comb begin
        w_in       = '{valid: bus.memory_valid, instr: bus.memory_instr,
                       addr: bus.memory_addr, wdata: bus.memory_wdata,
                       wstrb: bus.memory_wstrb};
        // A new request goes straight to active only when the active slot is
        // free next cycle and nothing is queued ahead of it.
        w_load_new = bus.memory_valid &&
                     (r_state == S_IDLE || (r_state == S_RESP && !r_pend.valid));
        w_promote  = (r_state == S_RESP) && r_pend.valid;
        w_load     = w_load_new || w_promote;
        w_load_req = w_promote ? r_pend : w_in;
        // In RESP with a full pending slot, the promotion frees the slot, so
        // the incoming request refills it in the same cycle.
        w_pend_fill = bus.memory_valid &&
                      ((r_state == S_WAIT && !r_pend.valid) || w_promote);
        w_drop      = bus.memory_valid && (r_state == S_WAIT) && r_pend.valid;
        w_go_resp   = (w_load && WAIT_STATES == 0) ||
                      (r_state == S_WAIT && r_cnt <= CW'(1));
        // The array is driven with whichever request will be active in RESP.
        w_acc       = w_load ? w_load_req : r_act;
        w_acc_ok    = idx_in_range(w_acc.addr[31:2], WORDS);
        w_arr_en    = w_go_resp && w_acc_ok;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_act      <= '0;
            r_pend     <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ready <= w_go_resp;
            r_error <= w_go_resp && !w_acc_ok;
            if (w_drop) r_overflow <= 1'b1;

            if (w_pend_fill)    r_pend <= w_in;
            else if (w_promote) r_pend <= '0;

            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_load) begin
                        r_act   <= w_load_req;
                        r_cnt   <= CNT_LOAD;
                        r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end else begin
                        r_act   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0)      r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt <= CW'(1))  r_state <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    mem_array #(.WORDS(WORDS)) u_array (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_arr_en),
        .i_idx   (w_acc.addr[AW+1:2]),
        .i_wstrb (w_acc.wstrb),
        .i_wdata (w_acc.wdata),
        .o_rdata (w_rdata)
    );

    assign bus.memory_rdata = w_rdata;
    assign bus.memory_ready = r_ready;
    assign bus.memory_error = r_error;
    assign o_overflow       = r_overflow;

    // The instr tag, byte offset and slot valid bit ride along without effect.
    logic w_unused_ok;
    assign w_unused_ok = ^{w_acc.valid, w_acc.instr, w_acc.addr[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed stimulus with a response scoreboard for mem_responder
// (WORDS=1024, WAIT_STATES=2).
// -----------------------------------------------------------------------------
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ovf;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    mem_responder_if bus();

    mem_responder #(.WORDS(1024), .WAIT_STATES(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus.slave),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pop one expectation per ready pulse; outside ready, rdata and
    // error must be zero.
    always @(negedge clk) begin
        exp_t e;
        if (bus.memory_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ready_cycle", cyc, e.cyc);
                chk("rdata", bus.memory_rdata, e.rdata);
                chk("error", {31'd0, bus.memory_error}, {31'd0, e.err});
            end
        end else if (rst_n) begin
            chk("idle_rdata_err", {bus.memory_rdata[31:1], bus.memory_rdata[0] | bus.memory_error}, 32'd0);
        end
    end

    // Issue a one-cycle request in the current cycle; optionally expect its
    // response delta cycles later.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input bit push, input logic [31:0] er, input logic ee, input int delta);
        exp_t e;
        bus.memory_valid = 1'b1;
        bus.memory_instr = 1'b0;
        bus.memory_addr  = a;
        bus.memory_wdata = wd;
        bus.memory_wstrb = st;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = cyc + delta;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.memory_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.memory_ready}, 32'd0);
        chk({tag, "_rdata"}, bus.memory_rdata, 32'd0);
        chk({tag, "_error"}, {31'd0, bus.memory_error}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        bus.memory_valid = 1'b0;
        bus.memory_instr = 1'b0;
        bus.memory_addr  = '0;
        bus.memory_wdata = '0;
        bus.memory_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        idle(1);

        // Write then read back the full word.
        issue(32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 1'b0, 3);
        idle(4);
        issue(32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0, 3);
        idle(4);

        // Requests arriving exactly in the RESP cycle with pending empty,
        // including a partial write.
        issue(32'h20, 32'h11223344, 4'hF, 1, 32'h0, 1'b0, 3);
        idle(2);
        issue(32'h20, 32'hAABBCCDD, 4'h5, 1, 32'h0, 1'b0, 3);
        idle(2);
        issue(32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 1'b0, 3);
        idle(2);
        issue(32'h13, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0, 3);   // byte offset ignored
        idle(4);
        chk("ovf_after_resp_arrivals", {31'd0, ovf}, 32'd0);

        // Pending full in RESP: promotion and refill in the same cycle.
        issue(32'h30, 32'h01020304, 4'hF, 1, 32'h0, 1'b0, 3);
        issue(32'h30, 32'h0, 4'h0, 1, 32'h01020304, 1'b0, 5);
        idle(1);
        issue(32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD, 1'b0, 6);
        idle(8);
        chk("ovf_after_refill", {31'd0, ovf}, 32'd0);

        // Third back-to-back request is dropped.
        issue(32'h40, 32'h0BADF00D, 4'hF, 1, 32'h0, 1'b0, 3);
        issue(32'h40, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 5);
        issue(32'h10, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b0, 0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        idle(6);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        issue(32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0, 3);   // dropped write had no effect
        idle(4);

        // Range boundaries.
        issue(32'h0, 32'hCAFEF00D, 4'hF, 1, 32'h0, 1'b0, 3);
        idle(4);
        issue(32'hFFC, 32'h600DF00D, 4'hF, 1, 32'h0, 1'b0, 3);
        idle(4);
        issue(32'hFFC, 32'h0, 4'h0, 1, 32'h600DF00D, 1'b0, 3);
        idle(4);
        issue(32'h1000, 32'h55555555, 4'hF, 1, 32'h0, 1'b1, 3);
        idle(4);
        issue(32'h1000, 32'h0, 4'h0, 1, 32'h0, 1'b1, 3);
        idle(4);
        issue(32'h80000000, 32'h12345678, 4'hF, 1, 32'h0, 1'b1, 3);
        idle(4);
        issue(32'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1'b0, 3);
        idle(4);

        // Reset in the middle of WAIT discards the request.
        issue(32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_assert");
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("rst_hold");
        rst_n = 1'b1;
        idle(2);
        chk_zero_outputs("rst_after");
        issue(32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0, 3);   // array survives reset

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        idle(3);
        chk("drain_outstanding", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
